// File: rtl/oh_to_idx_pipe_pkg.sv
// Purpose: shared constants and helpers for the one-hot-to-index pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: DIRECTION constants, idx_width() sizing helper, map_pos() bit-to-index map.
// Build option: OH_TO_IDX_PRIO_EN (used by oh_to_idx_lane) selects priority encoding.
package oh_to_idx_pipe_pkg;

  localparam string DIR_LSB0 = "LSB0";
  localparam string DIR_MSB0 = "MSB0";

  // Index width for an n-wide one-hot vector. Never below 1 bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Logical index of physical bit i. The mapping is its own inverse,
  // so it also converts a logical index back to a physical bit.
  function automatic int map_pos(input int i, input int n, input bit msb0);
    return msb0 ? (n - 1 - i) : i;
  endfunction

endpackage

// File: rtl/oh_to_idx_lane.sv
// Purpose: combinational one-hot encoder and malformed-input checker for one lane.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the parent pipeline owns all flow control.
// Ports: one_hot_i (NUM_SIGNALS) in; index_o (idx_width(NUM_SIGNALS)) out; err_o out (popcount != 1).
// Build option: OH_TO_IDX_PRIO_EN -> multi-hot input yields lowest logical index; otherwise OR of indices.
module oh_to_idx_lane
  import oh_to_idx_pipe_pkg::*;
#(
  parameter int    NUM_SIGNALS = 8,
  parameter string DIRECTION   = "LSB0",
  localparam int   IW          = idx_width(NUM_SIGNALS)
) (
  input  logic [NUM_SIGNALS-1:0] one_hot_i,
  output logic [IW-1:0]          index_o,
  output logic                   err_o
);

  localparam bit MSB0 = (DIRECTION == DIR_MSB0);

  logic seen;
  logic multi;

  // Error detection: track "at least one" and "more than one" set bits.
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < NUM_SIGNALS; i++) begin
      if (one_hot_i[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
    err_o = !seen || multi;
  end

`ifdef OH_TO_IDX_PRIO_EN
  // Walk logical indices from high to low so the lowest set one wins.
  always_comb begin
    index_o = '0;
    for (int p = NUM_SIGNALS - 1; p >= 0; p--) begin
      if (one_hot_i[map_pos(p, NUM_SIGNALS, MSB0)]) index_o = IW'(p);
    end
  end
`else
  // OR of all set-bit indices: exact for legal one-hot input, no priority chain.
  always_comb begin
    index_o = '0;
    for (int i = 0; i < NUM_SIGNALS; i++) begin
      if (one_hot_i[i]) index_o = index_o | IW'(map_pos(i, NUM_SIGNALS, MSB0));
    end
  end
`endif

endmodule

// File: rtl/oh_to_idx_pipe.sv
// Purpose: multi-lane pipelined one-hot-to-index encoder with malformed-input flags and error counter.
// Latency: PIPE_STAGES cycles (1 or 2) from input transfer to out_valid.
// Backpressure: bubble-collapsing stages; in_ready drops only when every stage is full and out_ready=0.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_one_hot (NUM_CH*NUM_SIGNALS);
//        out_valid/out_ready/out_index (NUM_CH*INDEX_WIDTH)/out_err (NUM_CH);
//        err_count (ERR_CNT_W, saturating), err_clr (sync clear, wins over increment).
// Build option: OH_TO_IDX_PRIO_EN -> priority encoding of multi-hot lanes (see oh_to_idx_lane).
module oh_to_idx_pipe
  import oh_to_idx_pipe_pkg::*;
#(
  parameter int    NUM_SIGNALS = 8,
  parameter int    NUM_CH      = 2,
  parameter string DIRECTION   = "LSB0",
  parameter int    PIPE_STAGES = 1,
  parameter int    ERR_CNT_W   = 8,
  localparam int   INDEX_WIDTH = idx_width(NUM_SIGNALS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_CH*NUM_SIGNALS-1:0] in_one_hot,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH*INDEX_WIDTH-1:0] out_index,
  output logic [NUM_CH-1:0]             out_err,
  output logic [ERR_CNT_W-1:0]          err_count,
  input  logic                          err_clr
);

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] index;
    logic                   err;
  } lane_res_t;

  logic [NUM_CH*NUM_SIGNALS-1:0] enc_src;
  logic                          src_vld;
  lane_res_t [NUM_CH-1:0]        enc_res;

  logic                   b_vld_q, b_vld_d;
  lane_res_t [NUM_CH-1:0] b_res_q, b_res_d;
  logic                   b_open;

  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  // Output stage can take new data when empty or draining this cycle.
  assign b_open = !b_vld_q || out_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    oh_to_idx_lane #(
      .NUM_SIGNALS (NUM_SIGNALS),
      .DIRECTION   (DIRECTION)
    ) u_lane (
      .one_hot_i (enc_src[c*NUM_SIGNALS +: NUM_SIGNALS]),
      .index_o   (enc_res[c].index),
      .err_o     (enc_res[c].err)
    );
  end

  if (PIPE_STAGES == 2) begin : g_two
    // Stage A holds the raw vector; encoding happens between A and B.
    logic                          a_vld_q, a_vld_d;
    logic [NUM_CH*NUM_SIGNALS-1:0] a_dat_q, a_dat_d;
    logic                          a_open;

    assign a_open   = !a_vld_q || b_open;
    assign in_ready = !rst && a_open;
    assign src_vld  = a_vld_q;
    assign enc_src  = a_dat_q;

    always_comb begin
      a_vld_d = a_vld_q;
      a_dat_d = a_dat_q;
      if (a_open) begin
        a_vld_d = in_valid;
        if (in_valid) a_dat_d = in_one_hot;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        a_vld_q <= 1'b0;
        a_dat_q <= '0;
      end else begin
        a_vld_q <= a_vld_d;
        a_dat_q <= a_dat_d;
      end
    end
  end else begin : g_one
    // Encode straight from the input port; only the result is registered.
    assign in_ready = !rst && b_open;
    assign src_vld  = in_valid;
    assign enc_src  = in_one_hot;
  end

  // Result is only replaced when new data arrives, so a stalled output holds.
  always_comb begin
    b_vld_d = b_vld_q;
    b_res_d = b_res_q;
    if (b_open) begin
      b_vld_d = src_vld;
      if (src_vld) b_res_d = enc_res;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = '0;
    end else if (b_vld_q && out_ready && (|out_err) && (cnt_q != {ERR_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_vld_q <= 1'b0;
      b_res_q <= '0;
      cnt_q   <= '0;
    end else begin
      b_vld_q <= b_vld_d;
      b_res_q <= b_res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = b_vld_q;
  assign err_count = cnt_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign out_index[c*INDEX_WIDTH +: INDEX_WIDTH] = b_res_q[c].index;
    assign out_err[c]                              = b_res_q[c].err;
  end

endmodule

// File: tb/tb_oh_to_idx_pipe.sv
// Purpose: self-checking bench for oh_to_idx_pipe; two instances share stimulus:
//          u_p1 (PIPE_STAGES=1, LSB0, 2-bit counter) and u_p2 (PIPE_STAGES=2, MSB0, 8-bit counter).
// Latency/backpressure are checked through per-instance scoreboards and occupancy.
module tb_oh_to_idx_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, err_clr;
  logic [15:0] in_one_hot;

  logic       in_ready1, out_valid1;
  logic [5:0] out_index1;
  logic [1:0] out_err1;
  logic [1:0] err_count1;

  logic       in_ready2, out_valid2;
  logic [5:0] out_index2;
  logic [1:0] out_err2;
  logic [7:0] err_count2;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected result word: {err[1:0], index1[2:0], index0[2:0]}
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int  cnt1, cnt2;
  bit  stall1, stall2;

  always #5 clk = ~clk;

  oh_to_idx_pipe #(.NUM_SIGNALS(8), .NUM_CH(2), .DIRECTION("LSB0"), .PIPE_STAGES(1), .ERR_CNT_W(2)) u_p1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_one_hot(in_one_hot),
    .out_valid(out_valid1), .out_ready(out_ready), .out_index(out_index1), .out_err(out_err1),
    .err_count(err_count1), .err_clr(err_clr));

  oh_to_idx_pipe #(.NUM_SIGNALS(8), .NUM_CH(2), .DIRECTION("MSB0"), .PIPE_STAGES(2), .ERR_CNT_W(8)) u_p2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_one_hot(in_one_hot),
    .out_valid(out_valid2), .out_ready(out_ready), .out_index(out_index2), .out_err(out_err2),
    .err_count(err_count2), .err_clr(err_clr));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: single-hot -> its logical position; zero -> 0; multi-hot -> OR of
  // logical positions (or the lowest one in the priority build). err = popcount != 1.
  function automatic logic [7:0] ref_vec(input logic [15:0] v, input bit msb0);
    logic [7:0] r;
    logic [7:0] lane;
    int idx, low, p;
    r = '0;
    for (int c = 0; c < 2; c++) begin
      lane = v[c*8 +: 8];
      idx  = 0;
      low  = 8;
      for (int i = 0; i < 8; i++) begin
        if (lane[i]) begin
          p   = msb0 ? 7 - i : i;
          idx = idx | p;
          if (p < low) low = p;
        end
      end
`ifdef OH_TO_IDX_PRIO_EN
      if ($countones(lane) > 1) idx = low;
`endif
      r[c*3 +: 3] = idx[2:0];
      r[6+c]      = ($countones(lane) != 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] rand_lane();
    int k;
    logic [7:0] l;
    k = $urandom_range(0, 9);
    if (k < 7)       l = 8'(1 << $urandom_range(0, 7));
    else if (k == 7) l = 8'h00;
    else             l = 8'($urandom);
    return l;
  endfunction

  // One clock cycle: drive at negedge, let comb settle, check, then update models
  // with the transfers that the coming posedge will perform.
  task automatic step(input bit r, input bit v, input logic [15:0] oh, input bit ordy, input bit clr);
    logic [7:0] e;
    @(negedge clk);
    rst = r; in_valid = v; in_one_hot = oh; out_ready = ordy; err_clr = clr;
    #1;
    if (r) begin
      check("rdy1_in_rst", in_ready1, 0);
      check("rdy2_in_rst", in_ready2, 0);
      q1.delete(); q2.delete();
      cnt1 = 0; cnt2 = 0; stall1 = 0; stall2 = 0;
      return;
    end
    check("cnt1", err_count1, cnt1);
    check("cnt2", err_count2, cnt2);
    check("rdy1", in_ready1, (q1.size() < 1) || ordy);
    check("rdy2", in_ready2, (q2.size() < 2) || ordy);
    check("vld1", out_valid1, q1.size() > 0);
    if (q2.size() == 2) check("vld2_full", out_valid2, 1);
    if (stall1) check("hold1", out_valid1, 1);
    if (stall2) check("hold2", out_valid2, 1);
    if (out_valid1) begin
      if (q1.size() == 0) check("spurious1", out_valid1, 0);
      else begin
        check("idx1", out_index1, q1[0][5:0]);
        check("err1", out_err1, q1[0][7:6]);
      end
    end
    if (out_valid2) begin
      if (q2.size() == 0) check("spurious2", out_valid2, 0);
      else begin
        check("idx2", out_index2, q2[0][5:0]);
        check("err2", out_err2, q2[0][7:6]);
      end
    end
    stall1 = out_valid1 && !ordy;
    stall2 = out_valid2 && !ordy;
    if (out_valid1 && ordy && q1.size() > 0) begin
      e = q1.pop_front();
      if (!clr && e[7:6] != 0 && cnt1 < 3) cnt1++;
    end
    if (out_valid2 && ordy && q2.size() > 0) begin
      e = q2.pop_front();
      if (!clr && e[7:6] != 0 && cnt2 < 255) cnt2++;
    end
    if (clr) begin cnt1 = 0; cnt2 = 0; end
    if (v && in_ready1) q1.push_back(ref_vec(oh, 1'b0));
    if (v && in_ready2) q2.push_back(ref_vec(oh, 1'b1));
  endtask

  logic [15:0] vecs[4];
  logic [15:0] errv;
  int ptr;
  bit ordy;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_one_hot = '0; out_ready = 1'b1; err_clr = 1'b0;
    cnt1 = 0; cnt2 = 0; stall1 = 0; stall2 = 0;

    // Reset state
    step(1, 0, '0, 1, 0);
    step(1, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    check("rst_vld1", out_valid1, 0);
    check("rst_vld2", out_valid2, 0);
    check("rst_idx1", out_index1, 0);
    check("rst_err2", out_err2, 0);

    // Latency and basic encoding: lane0=bit4, lane1=bit7
    step(0, 1, {8'h80, 8'h10}, 1, 0);
    step(0, 0, '0, 1, 0);
    check("lat1_vld", out_valid1, 1);
    check("lat1_idx", out_index1, {3'd7, 3'd4});
    check("lat1_err", out_err1, 2'b00);
    check("lat2_early", out_valid2, 0);
    step(0, 0, '0, 1, 0);
    check("lat2_vld", out_valid2, 1);
    check("msb0_idx", out_index2, {3'd0, 3'd3});
    check("lat1_gone", out_valid1, 0);

    // Malformed lanes: lane0 zero, lane1 bits 1 and 2
    step(0, 1, {8'h06, 8'h00}, 1, 0);
    step(0, 0, '0, 1, 0);
`ifdef OH_TO_IDX_PRIO_EN
    check("bad_idx1", out_index1, {3'd1, 3'd0});
`else
    check("bad_idx1", out_index1, {3'd3, 3'd0});
`endif
    check("bad_err1", out_err1, 2'b11);
    step(0, 0, '0, 1, 0);
    check("cnt1_one", err_count1, 1);
`ifdef OH_TO_IDX_PRIO_EN
    check("bad_idx2", out_index2, {3'd5, 3'd0});
`else
    check("bad_idx2", out_index2, {3'd7, 3'd0});
`endif
    step(0, 0, '0, 1, 0);
    check("cnt2_one", err_count2, 1);

    // Stream 4 vectors; out_ready low for cycles 2-5
    for (int i = 0; i < 4; i++) vecs[i] = {8'(1 << (7 - i)), 8'(1 << i)};
    ptr = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      ordy = !(cyc >= 2 && cyc <= 5);
      step(0, ptr < 4, (ptr < 4) ? vecs[ptr] : 16'h0, ordy, 0);
      if (in_valid && in_ready2) ptr++;
    end
    check("stream_all_in", ptr, 4);
    check("stream_drained", q2.size(), 0);

    // Counter saturation and clear-wins
    step(1, 0, '0, 1, 0);
    errv = {8'h03, 8'h00};
    for (int i = 0; i < 5; i++) step(0, 1, errv, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 0);
    check("sat1", err_count1, 3);
    check("sat2", err_count2, 5);
    step(0, 1, errv, 1, 0);
    step(0, 0, '0, 1, 1);
    step(0, 0, '0, 1, 0);
    check("clr_wins", err_count1, 0);

    // Reset with items in flight
    step(0, 1, {8'h01, 8'h00}, 0, 0);
    step(0, 1, {8'h02, 8'h00}, 0, 0);
    check("inflight2", q2.size(), 2);
    step(1, 0, '0, 0, 0);
    step(0, 0, '0, 1, 0);
    check("mid_rst_vld1", out_valid1, 0);
    check("mid_rst_vld2", out_valid2, 0);
    check("mid_rst_cnt1", err_count1, 0);
    check("mid_rst_cnt2", err_count2, 0);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(0, ($urandom_range(0, 3) != 0), {rand_lane(), rand_lane()},
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
    end

    // Bounded drain
    for (int i = 0; i < 20 && (q1.size() > 0 || q2.size() > 0); i++) step(0, 0, '0, 1, 0);
    check("drain1", q1.size(), 0);
    check("drain2", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
